// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the EX stage: quotient to LO, remainder to HI.
// Stalls the pipeline from the start cycle until the 32 steps complete.
module div_unit #(
    parameter int         WIDTH            = 32,
    parameter int         CNT_W            = 6,
    parameter logic [4:0] ALU_SIGNED_DIV   = 5'b11010,
    parameter logic [4:0] ALU_UNSIGNED_DIV = 5'b11011
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [4:0]       alucontrol_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             stall_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic               is_div, is_signed, start, last;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   rem, quo, divisor;
    logic               neg_q, neg_r;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     r_shift;
    logic [WIDTH-1:0]   r_sub, rem_nxt, quo_nxt;
    logic               fits;

    assign is_div    = (alucontrol_i == ALU_SIGNED_DIV) || (alucontrol_i == ALU_UNSIGNED_DIV);
    assign is_signed = (alucontrol_i == ALU_SIGNED_DIV);
    assign start     = valid_i && !flush_i && is_div && (state == IDLE);
    assign a_mag     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
    assign last      = (cnt == CNT_W'(WIDTH - 1));

    // The partial remainder always ends below the divisor, so only the shift needs the extra bit.
    assign r_shift = {rem, quo[WIDTH-1]};
    assign fits    = (r_shift >= {1'b0, divisor});
    assign r_sub   = r_shift[WIDTH-1:0] - divisor;
    assign rem_nxt = fits ? r_sub : r_shift[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], fits};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (b_i == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (flush_i || !stall_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_o = start || (state == BUSY);
        done_o  = (state == DONE);
    end

    // A flush abandons the divide without touching the architectural HI/LO values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (start) begin
            rem     <= '0;
            quo     <= a_mag;
            divisor <= b_mag;
            neg_q   <= is_signed && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r   <= is_signed && a_i[WIDTH-1];
            cnt     <= '0;
            if (b_i == '0) begin
                lo_o <= '1;
                hi_o <= a_i;
            end
        end else if (state == BUSY && !flush_i) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
                lo_o <= neg_q ? -quo_nxt : quo_nxt;
                hi_o <= neg_r ? -rem_nxt : rem_nxt;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit: latency, stall shape, signed/unsigned results,
// divide-by-zero, DONE hold, flush and mid-operation reset.
module tb_div_unit;

    localparam logic [4:0] OP_SDIV = 5'b11010;
    localparam logic [4:0] OP_UDIV = 5'b11011;
    localparam logic [4:0] OP_ADD  = 5'b00010;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn, valid, flush, stall_in;
    logic [4:0]  alucontrol;
    logic [31:0] a, b;
    logic        stall_o, done_o;
    logic [31:0] hi_o, lo_o;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_hi, last_lo;

    div_unit #(
        .WIDTH(32),
        .CNT_W(6),
        .ALU_SIGNED_DIV(OP_SDIV),
        .ALU_UNSIGNED_DIV(OP_UDIV)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .alucontrol_i(alucontrol),
        .valid_i(valid),
        .a_i(a),
        .b_i(b),
        .flush_i(flush),
        .stall_i(stall_in),
        .stall_o(stall_o),
        .done_o(done_o),
        .hi_o(hi_o),
        .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input bit sgn);
        exp_t   e;
        longint sx, sy;
        if (y == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = x;
        end else if (sgn) begin
            sx   = longint'($signed(x));
            sy   = longint'($signed(y));
            e.lo = 32'(sx / sy);
            e.hi = 32'(sx % sy);
        end else begin
            e.lo = x / y;
            e.hi = x % y;
        end
        return e;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y, input logic [4:0] op);
        @(negedge clk);
        valid      = 1'b1;
        alucontrol = op;
        a          = x;
        b          = y;
        #1;
    endtask

    task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input bit sgn, input int hold);
        int   n;
        int   stalls;
        exp_t e;
        sb.push_back(model(x, y, sgn));
        apply_stimulus(x, y, sgn ? OP_SDIV : OP_UDIV);
        check_output({tag, " start_stall"}, 32'(stall_o), 32'd1);
        stalls = 1;
        @(negedge clk);
        valid = 1'b0;
        #1;
        n = 0;
        while (done_o !== 1'b1 && n < 100) begin
            if (stall_o) stalls++;
            @(negedge clk);
            #1;
            n++;
        end
        check_output({tag, " latency"}, 32'(n), (y == 32'd0) ? 32'd0 : 32'd32);
        check_output({tag, " stall_cycles"}, 32'(stalls), (y == 32'd0) ? 32'd1 : 32'd33);
        check_output({tag, " stall_in_done"}, 32'(stall_o), 32'd0);
        check_output({tag, " queue_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output({tag, " lo"}, lo_o, e.lo);
            check_output({tag, " hi"}, hi_o, e.hi);
            last_hi = e.hi;
            last_lo = e.lo;
        end
        if (hold > 0) stall_in = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            #1;
            check_output({tag, " held_done"}, 32'(done_o), 32'd1);
            check_output({tag, " held_lo"}, lo_o, last_lo);
            check_output({tag, " held_hi"}, hi_o, last_hi);
            if (k == hold) stall_in = 1'b0;
        end
        @(negedge clk);
        #1;
        check_output({tag, " done_pulse_end"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        int seen;
        resetn     = 1'b0;
        valid      = 1'b0;
        flush      = 1'b0;
        stall_in   = 1'b0;
        alucontrol = 5'd0;
        a          = 32'd0;
        b          = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_output("reset done", 32'(done_o), 32'd0);
        check_output("reset stall", 32'(stall_o), 32'd0);
        check_output("reset hi", hi_o, 32'd0);
        check_output("reset lo", lo_o, 32'd0);
        resetn = 1'b1;

        run_div("u100/7", 32'd100, 32'd7, 1'b0, 0);
        run_div("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_div("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_div("u_max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_div("u_div0", 32'h0000_1234, 32'd0, 1'b0, 0);
        run_div("s_div0", 32'h8765_4321, 32'd0, 1'b1, 0);
        run_div("u_big_small", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
        run_div("hold3", 32'd1000, 32'd3, 1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            run_div("rand", $urandom, $urandom_range(1, 32'hFFFF), 1'(i % 2), 0);
        end

        apply_stimulus(32'd5, 32'd3, OP_ADD);
        check_output("nondiv stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        valid = 1'b0;
        #1;
        check_output("nondiv state", 32'(stall_o | done_o), 32'd0);

        flush = 1'b1;
        apply_stimulus(32'd50, 32'd5, OP_UDIV);
        check_output("idle_flush stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        #1;
        check_output("idle_flush state", 32'(stall_o | done_o), 32'd0);

        run_div("pre_flush", 32'd12345, 32'd67, 1'b0, 0);
        apply_stimulus(32'd500, 32'd7, OP_UDIV);
        @(negedge clk);
        valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_output("busy_flush stall", 32'(stall_o), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        check_output("busy_flush no_done", 32'(seen), 32'd0);
        check_output("busy_flush hi_kept", hi_o, last_hi);
        check_output("busy_flush lo_kept", lo_o, last_lo);
        run_div("post_flush", 32'hFFFF_FF00, 32'd9, 1'b1, 0);

        apply_stimulus(32'd999, 32'd4, OP_UDIV);
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        check_output("busy_reset done", 32'(done_o), 32'd0);
        check_output("busy_reset stall", 32'(stall_o), 32'd0);
        check_output("busy_reset hi", hi_o, 32'd0);
        check_output("busy_reset lo", lo_o, 32'd0);
        resetn = 1'b1;
        run_div("post_reset", 32'd81, 32'd9, 1'b0, 0);

        check_output("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
